// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Digit values, blank mask and decimal points are snapshotted once per frame
// so a frame never shows a mix of old and new values. Each digit slot opens
// with a blanking gap (all anodes off) to suppress ghosting between digits.
// Every output is registered; nothing combinational reaches a pin.

module seg7_scan_driver #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 1_000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] blank,
    input  logic [3:0] dp_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int DIV = CLK_HZ / REFRESH_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    // A slot must hold the blanking gap plus at least two lit cycles.
    generate
        if (DIV < BLANK_CYCLES + 2) begin : g_bad_params
            $fatal(1, "seg7_scan_driver: DIV=%0d must be >= BLANK_CYCLES+2=%0d",
                   DIV, BLANK_CYCLES + 2);
        end
    endgenerate

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h3F;
            4'h1:    pattern = 7'h06;
            4'h2:    pattern = 7'h5B;
            4'h3:    pattern = 7'h4F;
            4'h4:    pattern = 7'h66;
            4'h5:    pattern = 7'h6D;
            4'h6:    pattern = 7'h7D;
            4'h7:    pattern = 7'h07;
            4'h8:    pattern = 7'h7F;
            4'h9:    pattern = 7'h6F;
            4'hA:    pattern = 7'h77;
            4'hB:    pattern = 7'h7C;
            4'hC:    pattern = 7'h39;
            4'hD:    pattern = 7'h5E;
            4'hE:    pattern = 7'h79;
            default: pattern = 7'h71;
        endcase
        return pattern;
    endfunction

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    sh_digit [4];
    logic [3:0]    sh_blank;
    logic [3:0]    sh_dp;

    logic       snap;
    logic       show;
    logic [3:0] cur_digit;

    assign snap      = (cnt == '0) && (idx == 2'd0);
    assign cur_digit = sh_digit[idx];
    assign show      = (cnt >= BLANK_END) && !sh_blank[idx];

    // Slot timer and digit index; index steps on the last cycle of a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame snapshot of all display inputs, taken at the start of slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digit[0] <= 4'h0;
            sh_digit[1] <= 4'h0;
            sh_digit[2] <= 4'h0;
            sh_digit[3] <= 4'h0;
            sh_blank    <= 4'b1111;
            sh_dp       <= 4'b0000;
        end else if (snap) begin
            sh_digit[0] <= digit0;
            sh_digit[1] <= digit1;
            sh_digit[2] <= digit2;
            sh_digit[3] <= digit3;
            sh_blank    <= blank;
            sh_dp       <= dp_in;
        end
    end

    // Registered pin drivers: dark during the gap or for blanked digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= 4'b1111;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap;
            if (show) begin
                an  <= ~(4'b0001 << idx);
                seg <= ~seg_decode(cur_digit);
                dp  <= ~sh_dp[idx];
            end else begin
                an  <= 4'b1111;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with DIV=10, BLANK_CYCLES=2 (frame = 40 cycles).
// A reference model tracks the position within the frame and a per-frame
// snapshot, and derives the expected pins from slot arithmetic and a decode table.

module tb_seg7_scan_driver;

    logic       clk;
    logic       rst_n;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] blank;
    logic [3:0] dp_in;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_start;

    int vectors;
    int miscompares;

    seg7_scan_driver #(
        .CLK_HZ      (1000),
        .REFRESH_HZ  (100),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .blank      (blank),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [6:0] dec_tab [16];
    int         pos;
    logic [3:0] m_dig [4];
    logic [3:0] m_blank;
    logic [3:0] m_dp;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;

    initial begin
        dec_tab[0]  = 7'h3F; dec_tab[1]  = 7'h06; dec_tab[2]  = 7'h5B; dec_tab[3]  = 7'h4F;
        dec_tab[4]  = 7'h66; dec_tab[5]  = 7'h6D; dec_tab[6]  = 7'h7D; dec_tab[7]  = 7'h07;
        dec_tab[8]  = 7'h7F; dec_tab[9]  = 7'h6F; dec_tab[10] = 7'h77; dec_tab[11] = 7'h7C;
        dec_tab[12] = 7'h39; dec_tab[13] = 7'h5E; dec_tab[14] = 7'h79; dec_tab[15] = 7'h71;
    end

    // Model: position pos in a 40-cycle frame; slot = pos/10, offset = pos%10.
    always @(posedge clk or negedge rst_n) begin
        int slot;
        int offs;
        if (!rst_n) begin
            pos     = 0;
            m_dig[0] = 4'h0; m_dig[1] = 4'h0; m_dig[2] = 4'h0; m_dig[3] = 4'h0;
            m_blank = 4'b1111;
            m_dp    = 4'b0000;
            e_an    = 4'b1111;
            e_seg   = 7'h7F;
            e_dp    = 1'b1;
            e_fs    = 1'b0;
        end else begin
            slot = pos / 10;
            offs = pos % 10;
            e_an  = 4'b1111;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            if (offs >= 2 && !m_blank[slot]) begin
                e_an[slot] = 1'b0;
                e_seg      = ~dec_tab[m_dig[slot]];
                e_dp       = ~m_dp[slot];
            end
            e_fs = (pos == 0);
            if (pos == 0) begin
                m_dig[0] = digit0; m_dig[1] = digit1; m_dig[2] = digit2; m_dig[3] = digit3;
                m_blank  = blank;
                m_dp     = dp_in;
            end
            pos = (pos + 1) % 40;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        digit0 = 4'h7; digit1 = 4'h8; digit2 = 4'h9; digit3 = 4'hC;
        blank = 4'b0000; dp_in = 4'b0101;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({an, seg, dp, frame_start} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_dark: got an=%b seg=%h dp=%b fs=%b, want 1111/7f/1/0",
                         an, seg, dp, frame_start);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            vectors++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                miscompares++;
                $display("FAIL reset_model k=%0d: got %b/%h/%b/%b want %b/%h/%b/%b",
                         k, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
            end
            if (k == 1 || k == 2 || k == 41) begin
                vectors++;
                if (frame_start !== (k != 2)) begin
                    miscompares++;
                    $display("FAIL reset_frame_start k=%0d: got %b want %b", k, frame_start, k != 2);
                end
            end
        end
    endtask

    task automatic test_pattern();
        digit3 = 4'h1; digit2 = 4'h2; digit1 = 4'h3; digit0 = 4'hA;
        blank = 4'b0000; dp_in = 4'b0000;
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            vectors++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                miscompares++;
                $display("FAIL pattern_model k=%0d: got %b/%h/%b/%b want %b/%h/%b/%b",
                         k, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
            end
            if (k == 3 || k == 13 || k == 23 || k == 33) begin
                logic [3:0] want_an;
                logic [6:0] want_seg;
                case (k)
                    3:       begin want_an = 4'b1110; want_seg = 7'h08; end
                    13:      begin want_an = 4'b1101; want_seg = 7'h30; end
                    23:      begin want_an = 4'b1011; want_seg = 7'h24; end
                    default: begin want_an = 4'b0111; want_seg = 7'h79; end
                endcase
                vectors++;
                if ({an, seg} !== {want_an, want_seg}) begin
                    miscompares++;
                    $display("FAIL pattern_fixed k=%0d: got an=%b seg=%h want an=%b seg=%h",
                             k, an, seg, want_an, want_seg);
                end
            end
        end
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 16; v++) begin
            digit0 = v[3:0];
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                vectors++;
                if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                    miscompares++;
                    $display("FAIL sweep v=%0d k=%0d: got %b/%h/%b/%b want %b/%h/%b/%b",
                             v, k, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
                end
            end
        end
    endtask

    task automatic test_midframe();
        digit3 = 4'h0; digit2 = 4'h5; digit1 = 4'h1; digit0 = 4'h2;
        blank = 4'b0000; dp_in = 4'b0000;
        apply_reset();
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            vectors++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                miscompares++;
                $display("FAIL midframe_model k=%0d: got %b/%h/%b/%b want %b/%h/%b/%b",
                         k, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
            end
            if (k == 15) digit2 = 4'h9;
            if (k == 45) blank = 4'b0100;
            if (k == 23 || k == 63) begin
                vectors++;
                if ({an, seg} !== {4'b1011, (k == 23) ? 7'h12 : 7'h10}) begin
                    miscompares++;
                    $display("FAIL midframe_digit2 k=%0d: got an=%b seg=%h want an=1011 seg=%h",
                             k, an, seg, (k == 23) ? 7'h12 : 7'h10);
                end
            end
            if (k > 80) begin
                vectors++;
                if (an === 4'b1011) begin
                    miscompares++;
                    $display("FAIL midframe_blanked k=%0d: got an=%b want not 1011", k, an);
                end
            end
        end
    endtask

    task automatic test_dp();
        blank = 4'b0000; dp_in = 4'b1000;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            vectors++;
            if (dp !== !(an === 4'b0111)) begin
                miscompares++;
                $display("FAIL dp_slot k=%0d: got dp=%b an=%b want dp=%b", k, dp, an, !(an === 4'b0111));
            end
            vectors++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                miscompares++;
                $display("FAIL dp_model k=%0d: got %b/%h/%b/%b want %b/%h/%b/%b",
                         k, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int chg;
            chg = $urandom_range(0, 39);
            for (int k = 0; k < 40; k++) begin
                if (k == chg) begin
                    digit0 = 4'($urandom); digit1 = 4'($urandom);
                    digit2 = 4'($urandom); digit3 = 4'($urandom);
                    blank  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
                    dp_in  = 4'($urandom);
                end
                @(negedge clk);
                vectors++;
                if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                    miscompares++;
                    $display("FAIL random f=%0d k=%0d: got %b/%h/%b/%b want %b/%h/%b/%b",
                             f, k, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
                end
                vectors++;
                if ($countones(~an) > 1) begin
                    miscompares++;
                    $display("FAIL random_onehot: got an=%b want at most one low", an);
                end
            end
        end
    endtask

    task automatic test_reset_midslot();
        bit found;
        digit0 = 4'h4; digit1 = 4'h6; digit2 = 4'hE; digit3 = 4'hB;
        blank = 4'b0000; dp_in = 4'b0000;
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge clk);
            if (pos == 26) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL midreset_timeout: got no slot2/cnt6 point want one within 80 cycles");
        end else begin
            rst_n = 1'b0;
            #1;
            vectors++;
            if ({an, seg, dp, frame_start} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL midreset_dark: got %b/%h/%b/%b want 1111/7f/1/0",
                         an, seg, dp, frame_start);
            end
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            for (int k = 1; k <= 45; k++) begin
                @(negedge clk);
                vectors++;
                if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                    miscompares++;
                    $display("FAIL midreset_model k=%0d: got %b/%h/%b/%b want %b/%h/%b/%b",
                             k, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
                end
                if (k <= 3) begin
                    vectors++;
                    if (an !== ((k == 3) ? 4'b1110 : 4'b1111)) begin
                        miscompares++;
                        $display("FAIL midreset_restart k=%0d: got an=%b want %b",
                                 k, an, (k == 3) ? 4'b1110 : 4'b1111);
                    end
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_pattern();
        test_sweep();
        test_midframe();
        test_dp();
        test_random();
        test_reset_midslot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
